dut_vector_sequencer: RTL and testbench
=======================================

Name: dut_vector_sequencer

Overview:
- Parametrised engine that applies stored test vectors to the DUT pins and records the DUT's responses.
- Fetches each vector from a vector RAM and drives it onto the DUT bus, with per-bit direction set by a pinout mask.
- Waits a programmable settle time, then samples the DUT inputs. Writes each capture to a result RAM and compares it, under a mask, against an expected RAM.
- Sits between the AXI-lite config/status register file and the AXI-full-backed vector/result memories. Generalises the fixed 32-bit, 256-vector, 5-cycle burst FSM with width, depth, settle time, loop mode and on-chip compare.

Parameters:
- DUT_WIDTH, 32, DUT bus width in bits.
- ADDR_WIDTH, 8, vector address width; depth = 2**ADDR_WIDTH.
- SETTLE_W, 8, width of the settle-cycle counter.
- CNT_W, 16, width of the mismatch and round counters.

Ports:
- ACLK  in  1  clock. One clock domain; all logic is synchronous to ACLK.
- ARESET  in  1  asynchronous reset, active-high.
- go  in  1  level run request from status register bit 0.
- cfg_dir_mask  in  DUT_WIDTH  1 = pin driven by tester, 0 = pin sampled from DUT.
- cfg_burst_size  in  ADDR_WIDTH+1  number of vectors per round.
- cfg_settle  in  SETTLE_W  extra wait cycles between drive and capture.
- cfg_loop  in  1  1 = repeat rounds until go falls.
- vec_rd_en  out  1  vector/expected RAM read strobe.
- vec_addr  out  ADDR_WIDTH  vector/expected RAM address.
- vec_rd_data  in  DUT_WIDTH  vector data, valid 1 cycle after vec_rd_en.
- exp_rd_data  in  DUT_WIDTH  expected data, same timing as vec_rd_data.
- res_wr_en  out  1  result RAM write strobe.
- res_addr  out  ADDR_WIDTH  result RAM address.
- res_wr_data  out  DUT_WIDTH  captured value.
- dut_out  out  DUT_WIDTH  value driven toward the DUT.
- dut_oe  out  DUT_WIDTH  per-bit output enable; the pad tri-state lives outside this block.
- dut_in  in  DUT_WIDTH  pad input values.
- busy  out  1  high in every state except IDLE and DONE.
- finished  out  1  high in DONE.
- mismatch_count  out  CNT_W  count of failing vectors, saturating.
- first_fail_addr  out  ADDR_WIDTH  address of the first failing vector.
- round_count  out  CNT_W  completed rounds, wraps.

Behaviour:
- Reset values:
  - All outputs are 0; dut_oe = 0, so every pin is released.
  - FSM in IDLE.
- FSM states: IDLE, FETCH, LOAD, SETTLE, CAPTURE, NEXT, DONE.
- IDLE → FETCH on go = 1:
  - Latch cfg_* into internal registers; they are held for the whole run.
  - Clear mismatch_count, first_fail_addr and round_count; set addr = 0.
  - If latched burst_size = 0, go directly to DONE with no RAM access.
  - burst_size > 2**ADDR_WIDTH is clamped to 2**ADDR_WIDTH.
- FETCH: vec_rd_en = 1, vec_addr = addr.
- LOAD:
  - Register dut_out <= vec_rd_data, dut_oe <= dir_mask, exp_reg <= exp_rd_data.
  - Load the settle counter with cfg_settle.
- SETTLE:
  - Decrement the counter; leave when it is 0.
  - cfg_settle = 0 means a single pass through SETTLE.
- CAPTURE:
  - res_wr_en = 1, res_addr = addr, res_wr_data = dut_in.
  - Mismatch if ((dut_in ^ exp_reg) & ~dir_mask) != 0. On mismatch, mismatch_count +1, saturating at all-ones.
  - first_fail_addr is written only on the first mismatch of the run.
- NEXT:
  - If addr = burst_size-1: round_count +1. With loop = 1, set addr = 0 and go to FETCH; otherwise go to DONE.
  - Else addr +1 and go to FETCH.
- Timing:
  - Per-vector period = 5 + cfg_settle cycles.
  - With cfg_settle = 0 this is 5 cycles, matching the legacy FSM.
  - dut_out/dut_oe hold their values from LOAD until the next LOAD.
- DONE:
  - finished = 1, dut_oe = 0.
  - Stay until go = 0, then IDLE; finished clears on the same cycle.
  - Counters hold their values until the next start.
- go = 0 in any busy state aborts:
  - Next cycle is IDLE, dut_oe = 0, finished stays 0.
  - A result write already in CAPTURE on that cycle completes; no further writes.
- Loop mode:
  - finished never asserts.
  - Dropping go is the only exit, handled as an abort; counters are retained.
- ARESET mid-run:
  - Immediate return to reset values.
  - Pins are released asynchronously.

Decomposition:
- Package dut_seq_pkg:
  - state enum;
  - default widths;
  - PERIOD_BASE = 5.
- One natural sub-module, dut_seq_checker: masked compare plus saturating mismatch counter plus first-fail capture.
- The FSM and address counter stay in the top module.

Test Plan:
1. burst_size=4, settle=0, dir_mask=0x0000FFFF, vectors 0..3 = 0x1111, 0x2222, 0x3333, 0x4444, DUT loopback (in[31:16] = out[15:0]), expected = 0x11110000 etc.
   → 4 result writes at 5-cycle spacing, mismatch_count=0, finished rises 20 cycles after the first FETCH.
2. Same setup, expected[2] = 0xDEAD0000.
   → mismatch_count=1, first_fail_addr=2.
   → changing expected bits in the driven half only gives no mismatch.
3. settle=3 → vector period 8 cycles, measured between successive res_wr_en pulses.
   settle=255 → 260 cycles.
4. burst_size=0 → DONE on the cycle after the start, no vec_rd_en.
   burst_size=300 with ADDR_WIDTH=8 → exactly 256 writes, addresses 0..255.
5. loop=1, burst_size=2, go held for 3 rounds then dropped during SETTLE.
   → round_count=3, finished never 1, dut_oe=0 the cycle after go falls.
6. ARESET pulsed mid-CAPTURE → all outputs 0 asynchronously.
   Mismatches forced past 65535 → mismatch_count holds at 0xFFFF.

Source files
------------

// File: rtl/dut_seq_pkg.sv
// Shared widths, state codes and helpers for the vector sequencer slice.
package dut_seq_pkg;

   localparam int DEF_DUT_WIDTH  = 32;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_SETTLE_W   = 8;
   localparam int DEF_CNT_W      = 16;

   // Cycles per vector with zero extra settle: FETCH, LOAD, SETTLE, CAPTURE, NEXT.
   localparam int PERIOD_BASE = 5;

   typedef logic [2:0] seq_state_t;

   localparam seq_state_t ST_IDLE    = 3'd0;
   localparam seq_state_t ST_FETCH   = 3'd1;
   localparam seq_state_t ST_LOAD    = 3'd2;
   localparam seq_state_t ST_SETTLE  = 3'd3;
   localparam seq_state_t ST_CAPTURE = 3'd4;
   localparam seq_state_t ST_NEXT    = 3'd5;
   localparam seq_state_t ST_DONE    = 3'd6;

   function automatic logic is_busy_state(input seq_state_t s);
      return (s != ST_IDLE) && (s != ST_DONE);
   endfunction

endpackage

// File: rtl/dut_seq_checker.sv
// Masked response compare with a saturating mismatch counter and
// capture of the first failing vector address of a run.
module dut_seq_checker
   import dut_seq_pkg::*;
#(
   parameter int DUT_WIDTH  = DEF_DUT_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  clear,
   input  logic                  capture,
   input  logic [DUT_WIDTH-1:0]  sample,
   input  logic [DUT_WIDTH-1:0]  expected,
   input  logic [DUT_WIDTH-1:0]  dir_mask,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [CNT_W-1:0]      mismatch_count,
   output logic [ADDR_WIDTH-1:0] first_fail_addr
);

   logic [DUT_WIDTH-1:0]  bit_fail;
   logic                  fail;
   logic                  seen_fail_reg;
   logic [CNT_W-1:0]      mismatch_count_reg;
   logic [ADDR_WIDTH-1:0] first_fail_addr_reg;

   // Pins driven by the tester are never judged against the expected data.
   genvar gi;
   generate
      for (gi = 0; gi < DUT_WIDTH; gi++) begin : g_bit
         assign bit_fail[gi] = ~dir_mask[gi] & (sample[gi] ^ expected[gi]);
      end
   endgenerate

   assign fail = capture & (|bit_fail);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         seen_fail_reg       <= 1'b0;
         mismatch_count_reg  <= '0;
         first_fail_addr_reg <= '0;
      end else if (clear) begin
         seen_fail_reg       <= 1'b0;
         mismatch_count_reg  <= '0;
         first_fail_addr_reg <= '0;
      end else if (fail) begin
         if (~&mismatch_count_reg)
            mismatch_count_reg <= mismatch_count_reg + 1'b1;
         if (!seen_fail_reg) begin
            seen_fail_reg       <= 1'b1;
            first_fail_addr_reg <= addr;
         end
      end
   end

   assign mismatch_count  = mismatch_count_reg;
   assign first_fail_addr = first_fail_addr_reg;

endmodule

// File: rtl/dut_vector_sequencer.sv
// Applies stored vectors to the DUT pins, waits a settle time, captures the
// response into the result RAM and checks it against the expected RAM.
module dut_vector_sequencer
   import dut_seq_pkg::*;
#(
   parameter int DUT_WIDTH  = DEF_DUT_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int SETTLE_W   = DEF_SETTLE_W,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  go,
   input  logic [DUT_WIDTH-1:0]  cfg_dir_mask,
   input  logic [ADDR_WIDTH:0]   cfg_burst_size,
   input  logic [SETTLE_W-1:0]   cfg_settle,
   input  logic                  cfg_loop,
   output logic                  vec_rd_en,
   output logic [ADDR_WIDTH-1:0] vec_addr,
   input  logic [DUT_WIDTH-1:0]  vec_rd_data,
   input  logic [DUT_WIDTH-1:0]  exp_rd_data,
   output logic                  res_wr_en,
   output logic [ADDR_WIDTH-1:0] res_addr,
   output logic [DUT_WIDTH-1:0]  res_wr_data,
   output logic [DUT_WIDTH-1:0]  dut_out,
   output logic [DUT_WIDTH-1:0]  dut_oe,
   input  logic [DUT_WIDTH-1:0]  dut_in,
   output logic                  busy,
   output logic                  finished,
   output logic [CNT_W-1:0]      mismatch_count,
   output logic [ADDR_WIDTH-1:0] first_fail_addr,
   output logic [CNT_W-1:0]      round_count
);

   localparam logic [ADDR_WIDTH:0] DEPTH_VAL = {1'b1, {ADDR_WIDTH{1'b0}}};

   seq_state_t            state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg, last_addr_reg;
   logic [DUT_WIDTH-1:0]  dir_mask_reg, exp_reg, dut_out_reg, dut_oe_reg;
   logic [SETTLE_W-1:0]   settle_cfg_reg, settle_cnt_reg;
   logic                  loop_reg;
   logic [CNT_W-1:0]      round_reg;
   logic [ADDR_WIDTH:0]   burst_clamped, last_full;
   logic                  last_vec, start, capture;

   assign burst_clamped = (cfg_burst_size > DEPTH_VAL) ? DEPTH_VAL : cfg_burst_size;
   assign last_full     = burst_clamped - 1'b1;
   assign last_vec      = (addr_reg == last_addr_reg);
   assign start         = (state_reg == ST_IDLE) && go;
   assign capture       = (state_reg == ST_CAPTURE);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (go) state_next = (burst_clamped == '0) ? ST_DONE : ST_FETCH;
         ST_FETCH:   state_next = ST_LOAD;
         ST_LOAD:    state_next = ST_SETTLE;
         ST_SETTLE:  if (settle_cnt_reg == '0) state_next = ST_CAPTURE;
         ST_CAPTURE: state_next = ST_NEXT;
         ST_NEXT:    state_next = (last_vec && !loop_reg) ? ST_DONE : ST_FETCH;
         ST_DONE:    if (!go) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
      // Dropping go is the abort path from every active state, loop mode included.
      if (is_busy_state(state_reg) && !go)
         state_next = ST_IDLE;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_reg      <= ST_IDLE;
         addr_reg       <= '0;
         last_addr_reg  <= '0;
         dir_mask_reg   <= '0;
         exp_reg        <= '0;
         dut_out_reg    <= '0;
         dut_oe_reg     <= '0;
         settle_cfg_reg <= '0;
         settle_cnt_reg <= '0;
         loop_reg       <= 1'b0;
         round_reg      <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            ST_IDLE: if (go) begin
               dir_mask_reg   <= cfg_dir_mask;
               settle_cfg_reg <= cfg_settle;
               loop_reg       <= cfg_loop;
               last_addr_reg  <= last_full[ADDR_WIDTH-1:0];
               addr_reg       <= '0;
               round_reg      <= '0;
            end
            ST_LOAD: begin
               dut_out_reg    <= vec_rd_data;
               dut_oe_reg     <= dir_mask_reg;
               exp_reg        <= exp_rd_data;
               settle_cnt_reg <= settle_cfg_reg;
            end
            ST_SETTLE: if (settle_cnt_reg != '0) settle_cnt_reg <= settle_cnt_reg - 1'b1;
            ST_NEXT: if (go) begin
               if (last_vec) begin
                  round_reg <= round_reg + 1'b1;
                  addr_reg  <= '0;
               end else begin
                  addr_reg  <= addr_reg + 1'b1;
               end
            end
            default: ;
         endcase
         // Release every pin whenever the engine stops, whether finished or aborted.
         if (state_next == ST_IDLE || state_next == ST_DONE)
            dut_oe_reg <= '0;
      end
   end

   dut_seq_checker #(
      .DUT_WIDTH  (DUT_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .CNT_W      (CNT_W)
   ) u_checker (
      .ACLK            (ACLK),
      .ARESET          (ARESET),
      .clear           (start),
      .capture         (capture),
      .sample          (dut_in),
      .expected        (exp_reg),
      .dir_mask        (dir_mask_reg),
      .addr            (addr_reg),
      .mismatch_count  (mismatch_count),
      .first_fail_addr (first_fail_addr)
   );

   assign vec_rd_en   = (state_reg == ST_FETCH);
   assign vec_addr    = addr_reg;
   assign res_wr_en   = capture;
   assign res_addr    = addr_reg;
   assign res_wr_data = capture ? dut_in : '0;
   assign dut_out     = dut_out_reg;
   assign dut_oe      = dut_oe_reg;
   assign busy        = is_busy_state(state_reg);
   assign finished    = (state_reg == ST_DONE);
   assign round_count = round_reg;

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Randomised and directed bench for dut_vector_sequencer against a
// behavioural model of pads, vector RAMs and the per-run result stream.
module tb_dut_vector_sequencer;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int SW = 8;
   localparam int CW = 8;
   localparam int DEPTH = 256;
   localparam int SAT = 255;

   logic          tb_ACLK = 1'b0;
   logic          tb_ARESET = 1'b1;
   logic          go = 1'b0;
   logic [DW-1:0] cfg_dir_mask = '0;
   logic [AW:0]   cfg_burst_size = '0;
   logic [SW-1:0] cfg_settle = '0;
   logic          cfg_loop = 1'b0;
   logic          vec_rd_en;
   logic [AW-1:0] vec_addr;
   logic [DW-1:0] vec_rd_data = '0;
   logic [DW-1:0] exp_rd_data = '0;
   logic          res_wr_en;
   logic [AW-1:0] res_addr;
   logic [DW-1:0] res_wr_data, dut_out, dut_oe, dut_in;
   logic          busy, finished;
   logic [CW-1:0] mismatch_count, round_count;
   logic [AW-1:0] first_fail_addr;

   logic [DW-1:0] vec_mem [DEPTH];
   logic [DW-1:0] exp_mem [DEPTH];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_q[$];
   int rd_count, wr_count, first_rd_cyc, last_wr_cyc, exp_period, meas_period;
   int last_wr_addr, done_lat;
   logic [DW-1:0] first_wr_data;
   bit loop_run = 0;

   dut_vector_sequencer #(
      .DUT_WIDTH (DW), .ADDR_WIDTH (AW), .SETTLE_W (SW), .CNT_W (CW)
   ) dut (
      .ACLK (tb_ACLK), .ARESET (tb_ARESET), .go (go),
      .cfg_dir_mask (cfg_dir_mask), .cfg_burst_size (cfg_burst_size),
      .cfg_settle (cfg_settle), .cfg_loop (cfg_loop),
      .vec_rd_en (vec_rd_en), .vec_addr (vec_addr),
      .vec_rd_data (vec_rd_data), .exp_rd_data (exp_rd_data),
      .res_wr_en (res_wr_en), .res_addr (res_addr), .res_wr_data (res_wr_data),
      .dut_out (dut_out), .dut_oe (dut_oe), .dut_in (dut_in),
      .busy (busy), .finished (finished),
      .mismatch_count (mismatch_count), .first_fail_addr (first_fail_addr),
      .round_count (round_count)
   );

   always #5 tb_ACLK = ~tb_ACLK;
   always @(posedge tb_ACLK) cyc <= cyc + 1;

   // Pad model: driven pins read back their own value, the rest see the halves swapped.
   function automatic logic [DW-1:0] pad(input logic [DW-1:0] v, input logic [DW-1:0] m);
      logic [DW-1:0] resp;
      resp = {v[15:0], v[31:16]};
      return (v & m) | (resp & ~m);
   endfunction

   assign dut_in = pad(dut_out, dut_oe);

   always @(posedge tb_ACLK) begin
      if (vec_rd_en) begin
         vec_rd_data <= vec_mem[vec_addr];
         exp_rd_data <= exp_mem[vec_addr];
      end
   end

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic bit vec_fails(input int a, input logic [DW-1:0] m);
      return ((pad(vec_mem[a], m) ^ exp_mem[a]) & ~m) != '0;
   endfunction

   function automatic int model_mism(input int n, input int rounds, input logic [DW-1:0] m);
      int c = 0;
      for (int a = 0; a < n; a++) if (vec_fails(a, m)) c++;
      c = c * rounds;
      return (c > SAT) ? SAT : c;
   endfunction

   function automatic int model_first(input int n, input logic [DW-1:0] m);
      for (int a = 0; a < n; a++) if (vec_fails(a, m)) return a;
      return 0;
   endfunction

   // Compare process: every write is matched against the model's expected stream.
   always @(negedge tb_ACLK) begin
      int a;
      if (!tb_ARESET) begin
         if (vec_rd_en) begin
            rd_count++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
         end
         if (!busy) check("oe_released_when_idle", dut_oe, 0);
         if (loop_run) check("finished_in_loop", finished, 0);
         if (res_wr_en) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               a = exp_q.pop_front();
               check("res_addr", res_addr, a);
               check("res_wr_data", res_wr_data, pad(vec_mem[a], cfg_dir_mask));
               check("dut_out", dut_out, vec_mem[a]);
               check("dut_oe", dut_oe, cfg_dir_mask);
               if (last_wr_cyc >= 0) begin
                  meas_period = cyc - last_wr_cyc;
                  check("write_spacing", meas_period, exp_period);
               end
               if (wr_count == 0) first_wr_data = res_wr_data;
               last_wr_cyc  = cyc;
               last_wr_addr = res_addr;
               wr_count++;
            end
         end
      end
   end

   task automatic prep(input int burst, input int settle, input logic [DW-1:0] mask,
                       input int rounds);
      int n;
      n = (burst > DEPTH) ? DEPTH : burst;
      cfg_burst_size = burst[AW:0];
      cfg_settle     = settle[SW-1:0];
      cfg_dir_mask   = mask;
      exp_q.delete();
      for (int r = 0; r < rounds; r++)
         for (int a = 0; a < n; a++) exp_q.push_back(a);
      rd_count = 0; wr_count = 0; first_rd_cyc = -1; last_wr_cyc = -1;
      meas_period = 0; exp_period = 5 + settle;
   endtask

   task automatic run_burst(input int burst, input int settle, input logic [DW-1:0] mask);
      int n, budget, start_cyc;
      n = (burst > DEPTH) ? DEPTH : burst;
      cfg_loop = 1'b0;
      prep(burst, settle, mask, 1);
      @(negedge tb_ACLK);
      go = 1'b1;
      start_cyc = cyc;
      budget = n * (5 + settle) + 10;
      do begin
         @(negedge tb_ACLK);
         budget--;
      end while (!finished && budget > 0);
      check("finished_within_budget", finished, 1);
      done_lat = cyc - first_rd_cyc;
      if (n == 0) check("empty_burst_done_latency", cyc - start_cyc, 1);
      check("mismatch_count", mismatch_count, model_mism(n, 1, mask));
      check("first_fail_addr", first_fail_addr, model_first(n, mask));
      check("round_count", round_count, (n > 0) ? 1 : 0);
      check("write_count", wr_count, n);
      check("read_count", rd_count, n);
      check("pending_writes", exp_q.size(), 0);
      go = 1'b0;
      @(negedge tb_ACLK);
      check("finished_clears", finished, 0);
      check("busy_after_done", busy, 0);
   endtask

   task automatic load_basic();
      for (int i = 0; i < 4; i++) begin
         vec_mem[i] = 32'h1111 * (i + 1);
         exp_mem[i] = 32'h1111_0000 * (i + 1);
      end
   endtask

   task automatic load_random(input logic [DW-1:0] mask);
      for (int a = 0; a < DEPTH; a++) begin
         vec_mem[a] = $urandom;
         exp_mem[a] = pad(vec_mem[a], mask);
         if ($urandom_range(0, 2) == 0) exp_mem[a] ^= 32'h1 << $urandom_range(0, 31);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] mask;
      int budget;
      bit found;

      for (int a = 0; a < DEPTH; a++) begin
         vec_mem[a] = $urandom;
         exp_mem[a] = $urandom;
      end
      #12;
      check("reset_dut_oe", dut_oe, 0);
      check("reset_busy", busy, 0);
      check("reset_finished", finished, 0);
      check("reset_vec_rd_en", vec_rd_en, 0);
      check("reset_res_wr_en", res_wr_en, 0);
      @(negedge tb_ACLK);
      tb_ARESET = 1'b0;

      // Basic burst with loopback on the upper half.
      load_basic();
      run_burst(4, 0, 32'h0000_FFFF);
      check("basic_first_data", first_wr_data, 32'h1111_1111);
      check("basic_done_latency", done_lat, 20);
      check("basic_no_mismatch", mismatch_count, 0);

      // One bad expected word in the sampled half.
      exp_mem[2] = 32'hDEAD_0000;
      run_burst(4, 0, 32'h0000_FFFF);
      check("bad_exp_count", mismatch_count, 1);
      check("bad_exp_first", first_fail_addr, 2);

      // Empty burst straight to DONE, counters cleared by the new start.
      run_burst(0, 0, 32'h0000_FFFF);
      check("empty_no_reads", rd_count, 0);
      check("empty_count_cleared", mismatch_count, 0);

      // Differences only on driven pins are ignored.
      exp_mem[2] = 32'h3333_ABCD;
      run_burst(4, 0, 32'h0000_FFFF);
      check("driven_half_ignored", mismatch_count, 0);

      load_basic();
      run_burst(4, 3, 32'h0000_FFFF);
      check("settle3_period", meas_period, 8);
      run_burst(2, 255, 32'h0000_FFFF);
      check("settle255_period", meas_period, 260);

      // Oversized burst is clamped to the full depth.
      mask = $urandom;
      load_random(mask);
      run_burst(300, 0, mask);
      check("clamp_writes", wr_count, 256);
      check("clamp_last_addr", last_wr_addr, 255);

      // Every vector fails: counter must stick at all-ones.
      for (int a = 0; a < DEPTH; a++)
         exp_mem[a] = pad(vec_mem[a], 32'h0000_FFFF) ^ 32'h0001_0000;
      run_burst(256, 0, 32'h0000_FFFF);
      check("saturated_count", mismatch_count, 8'hFF);
      check("saturated_first", first_fail_addr, 0);

      // Randomised bursts.
      for (int it = 0; it < 6; it++) begin
         mask = $urandom;
         load_random(mask);
         run_burst($urandom_range(1, 24), $urandom_range(0, 4), mask);
      end

      // Loop mode: three rounds, then abort while settling.
      mask = $urandom;
      load_random(mask);
      prep(2, 2, mask, 3);
      cfg_loop = 1'b1;
      loop_run = 1'b1;
      @(negedge tb_ACLK);
      go = 1'b1;
      found = 1'b0;
      budget = 200;
      while (budget > 0 && !found) begin
         @(negedge tb_ACLK);
         budget--;
         if (round_count == 3 && vec_rd_en) found = 1'b1;
      end
      check("loop_reached_round3", found, 1);
      @(posedge tb_ACLK);
      @(posedge tb_ACLK);
      @(negedge tb_ACLK);
      go = 1'b0;
      @(negedge tb_ACLK);
      check("abort_dut_oe", dut_oe, 0);
      check("abort_busy", busy, 0);
      check("abort_finished", finished, 0);
      check("loop_round_count", round_count, 3);
      check("loop_mismatch_count", mismatch_count, model_mism(2, 3, mask));
      check("loop_pending_writes", exp_q.size(), 0);
      loop_run = 1'b0;
      cfg_loop = 1'b0;

      // Asynchronous reset in the middle of capturing vector 1.
      load_basic();
      exp_mem[0] = 32'hBAD0_0000;
      prep(4, 0, 32'h0000_FFFF, 1);
      @(negedge tb_ACLK);
      go = 1'b1;
      found = 1'b0;
      budget = 40;
      while (budget > 0 && !found) begin
         @(negedge tb_ACLK);
         budget--;
         if (res_wr_en && res_addr == 1) found = 1'b1;
      end
      check("reached_capture_1", found, 1);
      check("pre_reset_count", mismatch_count, 1);
      #2 tb_ARESET = 1'b1;
      #1;
      check("arst_dut_oe", dut_oe, 0);
      check("arst_dut_out", dut_out, 0);
      check("arst_res_wr_en", res_wr_en, 0);
      check("arst_busy", busy, 0);
      check("arst_mismatch_count", mismatch_count, 0);
      check("arst_vec_addr", vec_addr, 0);
      exp_q.delete();
      go = 1'b0;
      @(negedge tb_ACLK);
      tb_ARESET = 1'b0;
      @(negedge tb_ACLK);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
